// File: rtl/qbus_master.sv
// Q-bus (MPI) bus-cycle master: DATI, DATO(B), DATIO(B) and interrupt
// acknowledge cycles with address setup, RPLY synchronisation and an
// RPLY-timeout bus-error abort.
module qbus_master #(
  parameter int unsigned AW      = 16,
  parameter int unsigned SETUP   = 1,
  parameter int unsigned TO_W    = 6,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [1:0]    cmd,
  input  logic          byte_sel,
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] wdata,
  input  logic          wr_go,
  input  logic          rply,
  input  logic [AW-1:0] ad_in,
  output logic [AW-1:0] ad_out,
  output logic          ad_oe,
  output logic          sync,
  output logic          din,
  output logic          dout,
  output logic          wtbt,
  output logic          iako,
  output logic          busy,
  output logic          rd_valid,
  output logic [AW-1:0] rdata,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_SYNC, S_DATA, S_WAIT, S_END, S_RMW_HOLD, S_IAK
  } state_t;

  typedef enum logic [1:0] {
    CMD_RD = 2'b00, CMD_WR = 2'b01, CMD_RMW = 2'b10, CMD_IAK = 2'b11
  } cmd_t;

  state_t          state_q, state_d;
  cmd_t            cmd_q, cmd_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            byte_q, byte_d;
  logic            lane_q, lane_d;
  logic [AW-1:0]   wd_q, wd_d;
  logic            rply_m_q, rply_m_d, rply_s_q, rply_s_d;
  logic [AW-1:0]   ad_out_q, ad_out_d, rdata_q, rdata_d;
  logic            ad_oe_q, ad_oe_d, sync_q, sync_d, din_q, din_d;
  logic            dout_q, dout_d, wtbt_q, wtbt_d, iako_q, iako_d;
  logic            busy_q, busy_d, rd_valid_q, rd_valid_d;
  logic            done_q, done_d, err_q, err_d;
  logic            tmo, abort;
  logic [7:0]      lane_byte;

  // Byte writes place the low data byte on both lanes.
  function automatic logic [AW-1:0] bus_word(input logic b, input logic [AW-1:0] w);
    return b ? {(AW/8){w[7:0]}} : w;
  endfunction

  // Next-state, strobe and datapath decode; strobes are held unless changed.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    lane_d     = lane_q;
    wd_d       = wd_q;
    ad_out_d   = ad_out_q;
    rdata_d    = rdata_q;
    ad_oe_d    = ad_oe_q;
    sync_d     = sync_q;
    din_d      = din_q;
    dout_d     = dout_q;
    wtbt_d     = wtbt_q;
    iako_d     = iako_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rply_m_d   = rply;
    rply_s_d   = rply_m_q;
    tmo        = (cnt_q == TO_W'(TIMEOUT - 1));
    abort      = 1'b0;
    lane_byte  = lane_q ? ad_in[15:8] : ad_in[7:0];

    unique case (state_q)
      S_IDLE: begin
        // The done cycle is still busy, so a request there is not taken.
        if (req && !done_q) begin
          cmd_d  = cmd_t'(cmd);
          byte_d = byte_sel;
          lane_d = addr[0];
          wd_d   = wdata;
          cnt_d  = '0;
          if (cmd_t'(cmd) == CMD_IAK) begin
            state_d = S_IAK;
            din_d   = 1'b1;
          end else begin
            state_d  = S_ADDR;
            ad_oe_d  = 1'b1;
            ad_out_d = addr;
            wtbt_d   = (cmd_t'(cmd) == CMD_WR);
          end
        end
      end
      S_ADDR: begin
        if (cnt_q == TO_W'(SETUP - 1)) begin
          state_d = S_SYNC;
          sync_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SYNC: begin
        if (cmd_q == CMD_WR) begin
          state_d  = S_DATA;
          ad_out_d = bus_word(byte_q, wd_q);
          wtbt_d   = byte_q;
        end else begin
          state_d = S_WAIT;
          din_d   = 1'b1;
          ad_oe_d = 1'b0;
          wtbt_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        state_d = S_WAIT;
        dout_d  = 1'b1;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // din distinguishes the read phase from the write phase here.
        if (rply_s_q) begin
          cnt_d = '0;
          if (din_q) begin
            din_d      = 1'b0;
            rd_valid_d = 1'b1;
            rdata_d    = byte_q ? AW'(lane_byte) : ad_in;
            state_d    = (cmd_q == CMD_RMW) ? S_RMW_HOLD : S_END;
          end else begin
            dout_d  = 1'b0;
            state_d = S_END;
          end
        end else if (tmo) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_END: begin
        if (!rply_s_q) begin
          state_d = S_IDLE;
          sync_d  = 1'b0;
          ad_oe_d = 1'b0;
          wtbt_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else if (tmo) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RMW_HOLD: begin
        if (wr_go) begin
          wd_d     = wdata;
          state_d  = S_DATA;
          ad_oe_d  = 1'b1;
          ad_out_d = bus_word(byte_q, wdata);
          wtbt_d   = byte_q;
        end
      end
      S_IAK: begin
        if (rply_s_q) begin
          rdata_d    = ad_in;
          rd_valid_d = 1'b1;
          din_d      = 1'b0;
          iako_d     = 1'b0;
          state_d    = S_END;
          cnt_d      = '0;
        end else if (tmo) begin
          abort = 1'b1;
        end else begin
          iako_d = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      sync_d  = 1'b0;
      din_d   = 1'b0;
      dout_d  = 1'b0;
      wtbt_d  = 1'b0;
      iako_d  = 1'b0;
      ad_oe_d = 1'b0;
      done_d  = 1'b1;
      err_d   = 1'b1;
      cnt_d   = '0;
    end

    busy_d = (state_d != S_IDLE) || done_d;
  end

  // State, RPLY synchroniser and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= CMD_RD;
      cnt_q      <= '0;
      byte_q     <= 1'b0;
      lane_q     <= 1'b0;
      wd_q       <= '0;
      rply_m_q   <= 1'b0;
      rply_s_q   <= 1'b0;
      ad_out_q   <= '0;
      rdata_q    <= '0;
      ad_oe_q    <= 1'b0;
      sync_q     <= 1'b0;
      din_q      <= 1'b0;
      dout_q     <= 1'b0;
      wtbt_q     <= 1'b0;
      iako_q     <= 1'b0;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      lane_q     <= lane_d;
      wd_q       <= wd_d;
      rply_m_q   <= rply_m_d;
      rply_s_q   <= rply_s_d;
      ad_out_q   <= ad_out_d;
      rdata_q    <= rdata_d;
      ad_oe_q    <= ad_oe_d;
      sync_q     <= sync_d;
      din_q      <= din_d;
      dout_q     <= dout_d;
      wtbt_q     <= wtbt_d;
      iako_q     <= iako_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ad_out   = ad_out_q;
  assign ad_oe    = ad_oe_q;
  assign sync     = sync_q;
  assign din      = din_q;
  assign dout     = dout_q;
  assign wtbt     = wtbt_q;
  assign iako     = iako_q;
  assign busy     = busy_q;
  assign rd_valid = rd_valid_q;
  assign rdata    = rdata_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_qbus_master.sv
// Scoreboard bench for qbus_master: a stimulus process issues bus cycles and
// queues the expected outcome, a slave model answers strobes, and a monitor
// checks protocol shape and results whenever the master signals done.
`timescale 1ns/1ps
module tb_qbus_master;

  logic        clk = 1'b0;
  logic        rst, req, byte_sel, wr_go, rply;
  logic [1:0]  cmd;
  logic [15:0] addr, wdata, ad_in;
  logic [15:0] ad_out, rdata;
  logic        ad_oe, sync, din, dout, wtbt, iako, busy, rd_valid, done, err;

  qbus_master #(.AW(16), .SETUP(1), .TO_W(6), .TIMEOUT(40)) dut (
    .clk(clk), .rst(rst), .req(req), .cmd(cmd), .byte_sel(byte_sel),
    .addr(addr), .wdata(wdata), .wr_go(wr_go), .rply(rply), .ad_in(ad_in),
    .ad_out(ad_out), .ad_oe(ad_oe), .sync(sync), .din(din), .dout(dout),
    .wtbt(wtbt), .iako(iako), .busy(busy), .rd_valid(rd_valid),
    .rdata(rdata), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_iak, is_rmw, is_wr_cmd, err, has_rd, has_wr;
    logic [15:0] rdata, wbus;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ref_rdata = 16'h0;
  int          checks = 0, failures = 0;
  bit          in_rst = 1'b1;
  int          slv_dly = 0;
  bit          slv_nr = 1'b0;
  logic [15:0] slv_data = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Slave: answers din/dout after slv_dly cycles, releases RPLY when the strobe drops.
  initial begin : slave
    int cnt;
    cnt = 0; rply = 1'b0; ad_in = 16'h0;
    forever begin
      @(posedge clk); #1;
      if (din || dout) begin
        if (!rply) begin
          if (!slv_nr && cnt >= slv_dly) begin rply = 1'b1; ad_in = slv_data; end
          else begin cnt++; ad_in = 16'($urandom); end
        end
      end else begin
        rply = 1'b0; cnt = 0; ad_in = 16'($urandom);
      end
    end
  end

  // Monitor: tracks strobe history per cycle and scores each completed cycle.
  initial begin : monitor
    logic p_din, p_dout, p_sync, p_iako, p_oe;
    logic [15:0] p_ad, rd_val, wr_val;
    int din_run, rply_run, rply_lo, rd_cnt, sync_falls, iako_rises, iako_gap;
    bit sync_hi, wtbt_seen, wtbt_val, wr_seen, chk_busy, cur_iak;
    exp_t e;
    p_din = 0; p_dout = 0; p_sync = 0; p_iako = 0; p_oe = 0; p_ad = 0;
    din_run = 0; rply_run = 0; rply_lo = 0; chk_busy = 0;
    rd_cnt = 0; sync_falls = 0; iako_rises = 0; iako_gap = 0;
    sync_hi = 0; wtbt_seen = 0; wtbt_val = 0; wr_seen = 0; rd_val = 0; wr_val = 0;
    forever begin
      @(negedge clk);
      if (in_rst) begin
        din_run = 0; rply_run = 0; rply_lo = 0; chk_busy = 0;
        rd_cnt = 0; sync_falls = 0; iako_rises = 0; iako_gap = 0;
        sync_hi = 0; wtbt_seen = 0; wtbt_val = 0; wr_seen = 0;
      end else begin
        cur_iak = (exp_q.size() > 0) ? exp_q[0].is_iak : 1'b0;
        if (chk_busy) begin chk("busy_after_done", 32'(busy), 0); chk_busy = 0; end
        chk("err_only_with_done", 32'(err && !done), 0);
        if (sync) sync_hi = 1;
        if (ad_oe && !p_oe && !sync) begin wtbt_seen = 1; wtbt_val = wtbt; end
        if (din && !p_din && !cur_iak) chk("sync_before_din", 32'(p_sync), 1);
        if (!din && p_din && !done) chk("din_drop_after_rply_s", 32'(rply_run >= 3), 1);
        if (iako && !p_iako) begin iako_rises++; iako_gap = din_run; end
        if (dout && !p_dout) begin
          wr_seen = 1; wr_val = ad_out;
          chk("data_before_dout", 32'({p_oe, p_ad == ad_out}), 3);
        end
        if (rd_valid) begin rd_cnt++; rd_val = rdata; end
        if (!sync && p_sync && !done) sync_falls++;
        if (done) begin
          chk("strobes_low_at_done", 32'({sync, din, dout, iako, ad_oe, wtbt}), 0);
          if (exp_q.size() == 0) chk("done_without_cycle", 32'(exp_q.size()), 1);
          else begin
            e = exp_q.pop_front();
            chk("err", 32'(err), 32'(e.err));
            chk("rdata", 32'(rdata), 32'(e.rdata));
            chk("rd_valid_count", 32'(rd_cnt), 32'(e.has_rd));
            if (e.has_rd) chk("rdata_at_rd_valid", 32'(rd_val), 32'(e.rdata));
            if (e.has_wr) chk("write_bus", 32'({wr_seen, wr_val}), 32'({1'b1, e.wbus}));
            chk("wtbt_in_addr", 32'({wtbt_seen, wtbt_val}), 32'({!e.is_iak, e.is_wr_cmd}));
            if (e.is_iak) begin
              chk("sync_never_in_iak", 32'(sync_hi), 0);
              chk("iako_rises_once", 32'(iako_rises), 1);
              chk("iako_one_after_din", 32'(iako_gap), 1);
            end else begin
              chk("sync_continuous", 32'(sync_falls), 0);
              chk("sync_seen", 32'(sync_hi), 1);
            end
            if (!e.err) chk("done_after_rply_s_fall", 32'(rply_lo), 3);
          end
          chk_busy = 1;
          rd_cnt = 0; sync_falls = 0; iako_rises = 0; iako_gap = 0;
          sync_hi = 0; wtbt_seen = 0; wtbt_val = 0; wr_seen = 0;
        end
        din_run  = din  ? din_run + 1  : 0;
        rply_run = rply ? rply_run + 1 : 0;
        rply_lo  = rply ? 0 : rply_lo + 1;
      end
      p_din = din; p_dout = dout; p_sync = sync; p_iako = iako; p_oe = ad_oe; p_ad = ad_out;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_rst = 1'b1; req = 1'b0; wr_go = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_ctrl", 32'({sync, din, dout, wtbt, iako, ad_oe, busy, done, err, rd_valid}), 0);
    chk("reset_ad_out", 32'(ad_out), 0);
    chk("reset_rdata", 32'(rdata), 0);
    ref_rdata = 16'h0;
    exp_q.delete();
    @(posedge clk); #1;
    in_rst = 1'b0;
  endtask

  // One bus cycle: compute the expected outcome from the cycle's rules, queue it, drive it.
  task automatic do_txn(input logic [1:0] c, input logic b, input logic [15:0] a,
                        input logic [15:0] w, input logic [15:0] w2, input logic [15:0] sd,
                        input int dly, input bit nr, input int hold, input bit poke);
    exp_t e;
    logic [15:0] wv;
    bit fin;
    e.is_iak = (c == 2'b11); e.is_rmw = (c == 2'b10); e.is_wr_cmd = (c == 2'b01);
    e.err = nr;
    e.has_rd = !nr && (c != 2'b01);
    if (e.has_rd) ref_rdata = (e.is_iak || !b) ? sd : {8'h00, a[0] ? sd[15:8] : sd[7:0]};
    e.rdata = ref_rdata;
    wv = e.is_rmw ? w2 : w;
    e.has_wr = e.is_wr_cmd || (e.is_rmw && !nr);
    e.wbus = b ? {wv[7:0], wv[7:0]} : wv;
    slv_dly = dly; slv_nr = nr; slv_data = sd;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req = 1'b1; cmd = c; byte_sel = b; addr = a; wdata = w;
    @(posedge clk); #1;
    req = 1'b0; cmd = 2'($urandom); byte_sel = 1'($urandom);
    addr = 16'($urandom); wdata = 16'($urandom);
    if (e.is_rmw) begin
      fin = 0;
      for (int i = 0; i < 200 && !fin; i++) begin
        if (rd_valid || done) fin = 1;
        else begin @(posedge clk); #1; end
      end
      chk("rmw_read_phase_in_budget", 32'(fin), 1);
      if (rd_valid) begin
        repeat (hold) @(posedge clk);
        #1; wr_go = 1'b1; wdata = w2;
        @(posedge clk); #1; wr_go = 1'b0; wdata = 16'($urandom);
      end
    end
    fin = 0;
    for (int i = 0; i < 300 && !fin; i++) begin
      if (done) fin = 1;
      else begin
        if (poke && busy && i == 2) req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
      end
    end
    chk("done_in_budget", 32'(fin), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    bit fin;
    rst = 1'b1; req = 1'b0; cmd = 2'b00; byte_sel = 1'b0;
    addr = 16'h0; wdata = 16'h0; wr_go = 1'b0;
    do_reset();

    do_txn(2'b00, 1'b0, 16'o000300, 16'h0, 16'h0, 16'o012737, 3, 1'b0, 2, 1'b0);
    do_txn(2'b01, 1'b1, 16'o177567, 16'h0041, 16'h0, 16'h0, 2, 1'b0, 2, 1'b0);
    do_txn(2'b10, 1'b1, 16'o001001, 16'h1234, 16'h00A5, 16'h5A00, 2, 1'b0, 10, 1'b0);
    do_txn(2'b11, 1'b0, 16'o000200, 16'h0, 16'h0, 16'o000060, 2, 1'b0, 2, 1'b0);
    do_txn(2'b00, 1'b0, 16'o160000, 16'h0, 16'h0, 16'h0, 0, 1'b1, 2, 1'b0);

    // Reset in the middle of a read that is waiting with din asserted.
    slv_nr = 1'b1; slv_dly = 0;
    @(posedge clk); #1;
    req = 1'b1; cmd = 2'b00; byte_sel = 1'b0; addr = 16'o000300;
    @(posedge clk); #1;
    req = 1'b0;
    fin = 0;
    for (int i = 0; i < 20 && !fin; i++) begin
      if (din) fin = 1;
      else begin @(posedge clk); #1; end
    end
    chk("din_before_reset", 32'(fin), 1);
    repeat (3) @(posedge clk);
    do_reset();
    do_txn(2'b00, 1'b0, 16'o000400, 16'h0, 16'h0, 16'hBEEF, 1, 1'b0, 2, 1'b0);

    for (int n = 0; n < 60; n++)
      do_txn(2'($urandom_range(0, 3)), 1'($urandom), 16'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom), $urandom_range(0, 6),
             ($urandom_range(0, 9) == 0), $urandom_range(2, 12), ($urandom_range(0, 3) == 0));

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qbus_master.md
# qbus_master

Parametrised Q-bus (MPI) bus-cycle master for the ukfpga CPU core. It generalises the core's hard-wired instruction-fetch sequence into a reusable engine. The engine runs DATI, DATO/DATOB, DATIO/DATIOB (read-modify-write) and interrupt-acknowledge cycles. It has configurable address setup, RPLY synchronisation and a RPLY-timeout bus-error detector. It sits between the CPU microsequencer (request/done handshake) and the bidirectional AD pad ring.

## Interface
Parameters:
- `AW`, 16: address/data width of the AD bus.
- `SETUP`, 1: cycles AD holds the address before SYNC asserts (≥1).
- `TO_W`, 6: width of the RPLY timeout counter.
- `TIMEOUT`, 40: cycles waited for RPLY edge before bus error (< 2^TO_W).

Ports (all bus-side signals are logical active-high; the pads invert):
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: start a cycle; sampled only in IDLE.
- `cmd` in 2: 00 read, 01 write, 10 read-modify-write, 11 interrupt acknowledge.
- `byte` in 1: byte access; `addr[0]` selects the lane.
- `addr` in AW: bus address, latched at accept.
- `wdata` in AW: write data, latched at accept. For RMW it is latched again at `wr_go`.
- `wr_go` in 1: RMW write-phase release; sampled only in RMW_HOLD.
- `rply` in 1: raw RPLY from bus.
- `ad_in` in AW: AD pad input.
- `ad_out` out AW: AD pad output value.
- `ad_oe` out 1: AD pad output enable.
- `sync`, `din`, `dout`, `wtbt`, `iako` out 1: Q-bus control strobes.
- `busy` out 1: high whenever state ≠ IDLE.
- `rd_valid` out 1: one-cycle pulse when `rdata` is updated.
- `rdata` out AW: read or vector data.
- `done` out 1: one-cycle pulse at cycle end.
- `err` out 1: qualifies `done`; set on timeout.

## Operation
- RPLY passes through a 2-flop synchroniser (`rply_s`), giving 2 cycles of latency. Only `rply_s` is used internally.
- States: IDLE, ADDR, SYNC, DATA, WAIT, END, RMW_HOLD, IAK.
- IDLE, `req`=1: latch `cmd`/`byte`/`addr`/`wdata`.
  - `cmd`=11 → IAK.
  - Otherwise → ADDR.
- ADDR:
  - `ad_oe`=1, `ad_out`=addr.
  - `wtbt`=1 for write (cmd 01) only.
  - Stays SETUP cycles, then → SYNC.
- SYNC: `sync` rises; address still driven for one cycle.
  - Write → DATA.
  - Otherwise → WAIT with `din`=1 and `ad_oe`=0.
- DATA (write, or RMW write phase):
  - `ad_oe`=1, `wtbt`=`byte`.
  - `ad_out`: for a word, `wdata`; for a byte, `{wdata[7:0],wdata[7:0]}`.
  - `dout` rises one cycle after the data is driven, then → WAIT.
- WAIT: timeout counter increments each cycle.
  - Read phase: on `rply_s`=1, capture `rdata` and pulse `rd_valid`, then drop `din`.
    - For a byte, `rdata` = `{8'h00, addr[0] ? ad_in[15:8] : ad_in[7:0]}`.
  - Write phase: on `rply_s`=1, drop `dout`.
  - Then → END. RMW read phase → RMW_HOLD instead.
- END: wait `rply_s`=0. Then drop `sync`, release AD and pulse `done`, then → IDLE.
- RMW_HOLD: `sync` held, `din`/`dout` low, AD released.
  - Waits indefinitely for `wr_go`, then latches `wdata` → DATA.
- IAK:
  - `din` rises; `iako` rises the following cycle.
  - On `rply_s`=1, capture the full-word vector to `rdata` and pulse `rd_valid`.
  - Drop `din`/`iako`, wait `rply_s`=0, pulse `done`. `sync` is never asserted.
- Timeout: counter clears on entering WAIT, END or IAK.
  - Reaching TIMEOUT in any waiting state drops all strobes and releases AD.
  - Then `done`=`err`=1 for one cycle → IDLE; `rdata` is unchanged.
- `req` while busy is ignored; no queueing.
- Reset, including mid-cycle: next edge state=IDLE and counter=0.
  - All strobes, `ad_oe`, `busy`, `done`, `err` and `rd_valid` are 0.
  - `ad_out` and `rdata` are 0.

## Timing
- Read, SETUP=1, RPLY answered immediately:
  - accept edge n; `ad_oe` n+1; `sync` n+2; `din` n+3.
  - `rply_s` visible 2 cycles after raw `rply`.
  - `done` is the cycle after `rply_s` falls.
- Write: data is driven ≥1 cycle before `dout`; address is held ≥SETUP+1 cycles under `wtbt`.
- `done`, `rd_valid` and `err` are single-cycle pulses, never asserted together with `req` acceptance.
- `sync` is continuous across both halves of an RMW cycle.

## Test plan
- Word read, addr 0o000300, slave RPLY after 3 cycles with 0o012737 → `rdata`=0o012737, `err`=0, `sync` before `din` ≥1 cycle, `din` drops after `rply_s`.
- Byte write, addr 0o177567, `wdata`=0x0041 → `wtbt`=1 in ADDR, `ad_out`=0x4141 in DATA, `dout` asserted one cycle later, `done` after RPLY falls.
- RMW byte at odd addr 0o001001, read 0x5A00, `wr_go` held off 10 cycles → `rdata`=0x005A, `sync` continuous throughout, single `done` after write.
- Interrupt ack, slave returns vector 0o000060 → `iako` one cycle after `din`, `sync` never high, `rdata`=0o000060.
- No slave: TIMEOUT=40 → all strobes low, `done`=`err`=1 exactly once, `busy` drops next cycle.
- `rst` asserted during WAIT with `din`=1 → following edge: all outputs 0, state IDLE; a subsequent read completes normally.
